// File: rtl/counter3bit_pkg.sv
// rtl/counter3bit_pkg.sv - shared opcode/state types and default widths for the 3-bit counter controller
package counter3bit_pkg;

    localparam int CNT_W_DEF  = 3;
    localparam int WAIT_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_SAMPLE = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_LOAD   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STROBE = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/counter3bit_arb.sv
// rtl/counter3bit_arb.sv - two-requester arbiter; COUNTER3BIT_CTRL_RR_EN selects round-robin, else fixed priority to requester 0
module counter3bit_arb (
`ifdef COUNTER3BIT_CTRL_RR_EN
    input  logic clk,
    input  logic reset_n,
    input  logic i_accept,
`endif
    input  logic i_en,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant,
    output logic o_ready0,
    output logic o_ready1
);

    logic w_grant;

`ifdef COUNTER3BIT_CTRL_RR_EN
    logic r_ptr;

    // Pointer moves to the requester that lost, so it wins the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~w_grant;
        end
    end

    always_comb begin
        w_grant = i_valid1;
        if (i_valid0 && i_valid1) begin
            w_grant = r_ptr;
        end
    end
`else
    assign w_grant = i_valid1 && !i_valid0;
`endif

    assign o_grant  = w_grant;
    assign o_ready0 = i_en && i_valid0 && !w_grant;
    assign o_ready1 = i_en && i_valid1 && w_grant;

endmodule

// File: rtl/counter3bit_ctrl.sv
// rtl/counter3bit_ctrl.sv - command sequencer and arbiter driving the 3-bit counter strobes; COUNTER3BIT_CTRL_RR_EN enables round-robin
module counter3bit_ctrl
    import counter3bit_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [WAIT_W-1:0] req0_wait,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [WAIT_W-1:0] req1_wait,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  rsp_count,
    output logic              ctr_reset,
    output logic              ctr_set,
    output logic              ctr_load,
    input  logic [CNT_W-1:0]  ctr_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_id;
    logic [CNT_W-1:0]  r_rsp_count;
    logic              r_ctr_reset;
    logic              r_ctr_set;
    logic              r_ctr_load;

    logic              w_idle;
    logic              w_grant;
    logic              w_accept;
    op_t               w_op_sel;
    logic [WAIT_W-1:0] w_wait_sel;

    // Readies are held low while reset is asserted, not just after it.
    assign w_idle     = (r_state == ST_IDLE) && reset_n;
    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_op_sel   = op_t'(w_grant ? req1_op : req0_op);
    assign w_wait_sel = w_grant ? req1_wait : req0_wait;

    counter3bit_arb u_arb (
`ifdef COUNTER3BIT_CTRL_RR_EN
        .clk      (clk),
        .reset_n  (reset_n),
        .i_accept (w_accept),
`endif
        .i_en     (w_idle),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_grant  (w_grant),
        .o_ready0 (req0_ready),
        .o_ready1 (req1_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_state_nxt = (r_wait != '0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the accepted op at the accept edge so they are
    // clean registered pulses covering exactly the STROBE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait      <= '0;
            r_wait_cnt  <= '0;
            r_id        <= 1'b0;
            r_rsp_count <= '0;
            r_ctr_reset <= 1'b0;
            r_ctr_set   <= 1'b0;
            r_ctr_load  <= 1'b0;
        end else begin
            r_ctr_reset <= w_accept && (w_op_sel == OP_RESET);
            r_ctr_set   <= w_accept && (w_op_sel == OP_SET);
            r_ctr_load  <= w_accept && (w_op_sel == OP_LOAD);
            if (w_accept) begin
                r_id   <= w_grant;
                r_wait <= w_wait_sel;
            end
            if (r_state == ST_STROBE) begin
                r_wait_cnt <= r_wait;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
            end
            if ((w_state_nxt == ST_RESP) && (r_state != ST_RESP)) begin
                r_rsp_count <= ctr_count;
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_count = r_rsp_count;
    assign ctr_reset = r_ctr_reset;
    assign ctr_set   = r_ctr_set;
    assign ctr_load  = r_ctr_load;

endmodule

// File: tb/tb_counter3bit_ctrl.sv
// tb/tb_counter3bit_ctrl.sv - scoreboard bench for counter3bit_ctrl with a behavioural counter on ctr_*; honours COUNTER3BIT_CTRL_RR_EN
module tb_counter3bit_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [2:0] req0_wait, req1_wait;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [2:0] rsp_count;
    logic       ctr_reset, ctr_set, ctr_load;
    logic [2:0] ctr_count;
    logic [2:0] m_cnt;

    always #5 clk = ~clk;

    counter3bit_ctrl #(.CNT_W(3), .WAIT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_wait  (req0_wait),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_wait  (req1_wait),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_count  (rsp_count),
        .ctr_reset  (ctr_reset),
        .ctr_set    (ctr_set),
        .ctr_load   (ctr_load),
        .ctr_count  (ctr_count)
    );

    // Free-running counter standing in for the real counter instance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       m_cnt <= 3'd0;
        else if (ctr_reset) m_cnt <= 3'd0;
        else if (ctr_set)   m_cnt <= 3'd7;
        else if (ctr_load)  m_cnt <= 3'd5;
        else                m_cnt <= m_cnt + 3'd1;
    end
    assign ctr_count = m_cnt;

    typedef struct packed { logic [1:0] op; logic [2:0] w; } cmd_t;
    typedef struct { logic id; logic [2:0] cnt; logic [2:0] w; int acc; } exp_t;

    cmd_t       q0[$];
    cmd_t       q1[$];
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cyc = -10;
    int         bp_left = 0;
    logic       busy = 1'b0;
    logic       m_ptr = 1'b0;
    logic       rsp_seen = 1'b0;
    logic [1:0] cur_op = 2'b00;
    logic [2:0] held_cnt = 3'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic model_grant();
        if (req0_valid && req1_valid) return m_ptr;
        return req1_valid;
    endfunction

    function automatic logic [2:0] strobe_of(input logic [1:0] op);
        case (op)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // m is the counter value during the STROBE cycle; wait=0 samples it before the strobe lands.
    function automatic logic [2:0] exp_count(input logic [1:0] op, input logic [2:0] w, input logic [2:0] m);
        logic [2:0] s;
        case (op)
            2'b01:   s = 3'd0;
            2'b10:   s = 3'd7;
            2'b11:   s = 3'd5;
            default: s = m + 3'd1;
        endcase
        if (w == 3'd0) return m;
        return 3'(int'(s) + int'(w) - 1);
    endfunction

    task automatic drive_inputs();
        req0_valid = (q0.size() > 0);
        req0_op    = req0_valid ? q0[0].op : 2'b00;
        req0_wait  = req0_valid ? q0[0].w  : 3'd0;
        req1_valid = (q1.size() > 0);
        req1_op    = req1_valid ? q1[0].op : 2'b00;
        req1_wait  = req1_valid ? q1[0].w  : 3'd0;
    endtask

    task automatic tick();
        logic g, acc, hs;
        cmd_t cur;
        @(negedge clk);
        cyc++;
        g   = model_grant();
        acc = !busy && (req0_valid || req1_valid);
        check("ready0", req0_ready, !busy && req0_valid && !g);
        check("ready1", req1_ready, !busy && req1_valid && g);
        check("strobes", {ctr_reset, ctr_set, ctr_load},
              (busy && cyc == acc_cyc + 1) ? strobe_of(cur_op) : 3'b000);
        if (!busy) check("rsp_idle", rsp_valid, 1'b0);
        rsp_ready = (bp_left == 0);
        hs = 1'b0;
        if (rsp_valid && busy) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                if (!rsp_seen) begin
                    check("rsp_latency", cyc - sb[0].acc, 2 + int'(sb[0].w));
                    held_cnt = rsp_count;
                    rsp_seen = 1'b1;
                end else begin
                    check("rsp_hold", rsp_count, held_cnt);
                end
                if (rsp_ready) begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_count", rsp_count, sb[0].cnt);
                    void'(sb.pop_front());
                    hs = 1'b1;
                end else begin
                    bp_left--;
                end
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            if (g) cur = q1.pop_front();
            else   cur = q0.pop_front();
            cur_op = cur.op;
            sb.push_back('{g, exp_count(cur.op, cur.w, m_cnt), cur.w, cyc});
`ifdef COUNTER3BIT_CTRL_RR_EN
            m_ptr = ~g;
`endif
        end
        if (hs) begin
            busy     = 1'b0;
            rsp_seen = 1'b0;
        end
        drive_inputs();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", n < max_cycles, 1'b1);
    endtask

    task automatic push_rand(input logic which);
        cmd_t c;
        c.op = 2'($urandom_range(0, 3));
        c.w  = 3'($urandom_range(0, 7));
        if (which) q1.push_back(c);
        else       q0.push_back(c);
    endtask

    initial begin
        rsp_ready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_count", rsp_count, 3'd0);
        check("rst_strobes", {ctr_reset, ctr_set, ctr_load}, 3'b000);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        drive_inputs();
        reset_n = 1'b1;

        q0.push_back('{2'b01, 3'd0});
        drive_inputs();
        run_until_idle(50);

        q1.push_back('{2'b10, 3'd3});
        drive_inputs();
        run_until_idle(50);

        q0.push_back('{2'b00, 3'd7});
        q0.push_back('{2'b11, 3'd1});
        drive_inputs();
        run_until_idle(50);

        bp_left = 4;
        q1.push_back('{2'b11, 3'd2});
        q0.push_back('{2'b00, 3'd0});
        drive_inputs();
        run_until_idle(60);

        for (int i = 0; i < 4; i++) begin
            push_rand(1'b0);
            push_rand(1'b1);
        end
        drive_inputs();
        run_until_idle(200);

        for (int i = 0; i < 20; i++) begin
            push_rand(1'($urandom_range(0, 1)));
        end
        drive_inputs();
        run_until_idle(400);

        q0.push_back('{2'b01, 3'd5});
        drive_inputs();
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_rsp_count", rsp_count, 3'd0);
        check("midrst_strobes", {ctr_reset, ctr_set, ctr_load}, 3'b000);
        check("midrst_ready", {req0_ready, req1_ready}, 2'b00);
        busy     = 1'b0;
        rsp_seen = 1'b0;
        m_ptr    = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) tick();

        q0.push_back('{2'b10, 3'd1});
        q1.push_back('{2'b11, 3'd0});
        drive_inputs();
        run_until_idle(50);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
